// File: rtl/wb_memory_slave_if.sv
// Wishbone B4 classic bus bundle between a load/store master and the memory slave.
// Optional feature macro: DPROC_WB_SLAVE_ERR_EN adds the wb_err_o error-termination line.
interface wb_memory_slave_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;
`ifdef DPROC_WB_SLAVE_ERR_EN
  logic        wb_err_o;
`endif

`ifdef DPROC_WB_SLAVE_ERR_EN
  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );
  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
`else
  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o
  );
  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o
  );
`endif
endinterface

// File: rtl/wb_memory_slave.sv
// Wishbone B4 classic single-port memory responder: registered word-addressed RAM
// with byte-lane writes, programmable wait states and address-range decode.
// Optional feature macro: DPROC_WB_SLAVE_ERR_EN -- out-of-range accesses terminate
// with wb_err_o instead of wb_ack_o.
module wb_memory_slave #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic clk_i,
  input logic rst_i,
  wb_memory_slave_if.slave bus
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WS   = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  // Byte address with the lane bits cleared; BASE_ADDR is word aligned.
  function automatic logic [31:0] align_addr(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  function automatic logic addr_in_range(input logic [31:0] a);
    logic [31:0] off;
    off = align_addr(a) - BASE_ADDR;
    return (align_addr(a) >= BASE_ADDR) && (off < SPAN);
  endfunction

  function automatic logic [AW-1:0] word_index(input logic [31:0] a);
    logic [31:0] off;
    off = align_addr(a) - BASE_ADDR;
    return AW'(off >> 2);
  endfunction

  logic [31:0] mem [0:DEPTH_WORDS-1];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
`ifdef DPROC_WB_SLAVE_ERR_EN
  logic        err_q, err_d;
`endif

  logic        req_s;
  logic        enter_ack_s;
  logic [31:0] c_adr_s, c_dat_s;
  logic        c_we_s;
  logic [3:0]  c_sel_s;
  logic        c_hit_s;
  logic        wr_en_s;

  assign req_s = bus.wb_cyc_i & bus.wb_stb_i;

  // Next-state, capture and wait-count logic; also selects the transfer being committed.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    we_d        = we_q;
    sel_d       = sel_q;
    enter_ack_s = 1'b0;
    c_adr_s     = adr_q;
    c_dat_s     = dat_q;
    c_we_s      = we_q;
    c_sel_s     = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          adr_d = bus.wb_adr_i;
          dat_d = bus.wb_dat_i;
          we_d  = bus.wb_we_i;
          sel_d = bus.wb_sel_i;
          cnt_d = WS;
          if (WS == 4'd0) begin
            // Zero wait states: commit straight from the bus on the sampling edge.
            state_d     = ST_ACK;
            enter_ack_s = 1'b1;
            c_adr_s     = bus.wb_adr_i;
            c_dat_s     = bus.wb_dat_i;
            c_we_s      = bus.wb_we_i;
            c_sel_s     = bus.wb_sel_i;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!bus.wb_cyc_i) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d     = ST_ACK;
          cnt_d       = 4'd0;
          enter_ack_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Response generation on the edge entering ACK; everything clears on the edge leaving it.
  always_comb begin
    c_hit_s = addr_in_range(c_adr_s);
    wr_en_s = enter_ack_s & c_we_s & c_hit_s;
    if (enter_ack_s && !c_we_s && c_hit_s) begin
      rdata_d = mem[word_index(c_adr_s)];
    end else begin
      rdata_d = 32'h0000_0000;
    end
`ifdef DPROC_WB_SLAVE_ERR_EN
    ack_d = enter_ack_s & c_hit_s;
    err_d = enter_ack_s & ~c_hit_s;
`else
    ack_d = enter_ack_s;
`endif
  end

  // State, capture registers and registered bus outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      adr_q   <= 32'h0000_0000;
      dat_q   <= 32'h0000_0000;
      we_q    <= 1'b0;
      sel_q   <= 4'h0;
      ack_q   <= 1'b0;
      rdata_q <= 32'h0000_0000;
`ifdef DPROC_WB_SLAVE_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
`ifdef DPROC_WB_SLAVE_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  // RAM byte-lane write port; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_en_s) begin
      for (int b = 0; b < 4; b++) begin
        if (c_sel_s[b]) begin
          mem[word_index(c_adr_s)][8*b +: 8] <= c_dat_s[8*b +: 8];
        end
      end
    end
  end

  assign bus.wb_ack_o = ack_q;
  assign bus.wb_dat_o = rdata_q;
`ifdef DPROC_WB_SLAVE_ERR_EN
  assign bus.wb_err_o = err_q;
`endif

endmodule
